// File: rtl/fifo_pkg.sv
// Shared definitions for param_fifo: FSM state encodings and error-counter width.
package fifo_pkg;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_WR_ERROR = 3'd3;
    localparam logic [2:0] ST_RD_ERROR = 3'd4;
    localparam logic [2:0] ST_NO_OP    = 3'd5;
    localparam logic [2:0] ST_WR_RD    = 3'd6;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        S_INIT     = ST_INIT,
        S_WRITE    = ST_WRITE,
        S_READ     = ST_READ,
        S_WR_ERROR = ST_WR_ERROR,
        S_RD_ERROR = ST_RD_ERROR,
        S_NO_OP    = ST_NO_OP,
        S_WR_RD    = ST_WR_RD
    } fifo_state_e;

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer handshake and status bundle for param_fifo.
// Error-counter signals exist only when PARAM_FIFO_ERR_CNT_EN is defined.
interface param_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    import fifo_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic [CNT_W-1:0]      data_count;
    logic [2:0]            state;
`ifdef PARAM_FIFO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0]  wr_err_cnt;
    logic [ERR_CNT_W-1:0]  rd_err_cnt;
`endif

    modport master (
        output wr_en, rd_en, d_in,
`ifdef PARAM_FIFO_ERR_CNT_EN
        input  wr_err_cnt, rd_err_cnt,
`endif
        input  d_out, full, empty, almost_full, almost_empty,
        input  wr_ack, wr_err, rd_ack, rd_err, data_count, state
    );

    modport slave (
        input  wr_en, rd_en, d_in,
`ifdef PARAM_FIFO_ERR_CNT_EN
        output wr_err_cnt, rd_err_cnt,
`endif
        output d_out, full, empty, almost_full, almost_empty,
        output wr_ack, wr_err, rd_ack, rd_err, data_count, state
    );

endinterface

// File: rtl/param_fifo_ns.sv
// Combinational next-state decode for param_fifo; the decision depends only on
// the requests and the current occupancy, so every state shares one transition table.
module param_fifo_ns
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [CNT_W-1:0] data_count,
    input  fifo_state_e      state,
    output fifo_state_e      next_state,
    output logic             rd_err_nxt
);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic w_empty;

    assign w_empty = (data_count == '0);

    always_comb begin
        next_state = S_NO_OP;
        rd_err_nxt = 1'b0;
        case ({wr_en, rd_en})
            2'b10: next_state = (data_count < FULL_C) ? S_WRITE : S_WR_ERROR;
            2'b01: begin
                next_state = w_empty ? S_RD_ERROR : S_READ;
                rd_err_nxt = w_empty;
            end
            2'b11: begin
                // an empty FIFO can still take the write; only the read half is refused
                next_state = w_empty ? S_WRITE : S_WR_RD;
                rd_err_nxt = w_empty;
            end
            default: next_state = S_NO_OP;
        endcase
        assert (state inside {S_INIT, S_WRITE, S_READ, S_WR_ERROR,
                              S_RD_ERROR, S_NO_OP, S_WR_RD});
    end

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO: state register, pointer/count datapath, memory and flags.
// Defining PARAM_FIFO_ERR_CNT_EN adds saturating write/read error counters.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    param_fifo_if.slave fifo
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_wr_ack;
    logic                  r_wr_err;
    logic                  r_rd_ack;
    logic                  r_rd_err;
    fifo_state_e           r_state;
    fifo_state_e           w_next_state;
    logic                  w_rd_err_nxt;
    logic                  w_do_wr;
    logic                  w_do_rd;

    param_fifo_ns #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ns (
        .wr_en      (fifo.wr_en),
        .rd_en      (fifo.rd_en),
        .data_count (r_count),
        .state      (r_state),
        .next_state (w_next_state),
        .rd_err_nxt (w_rd_err_nxt)
    );

    assign w_do_wr = (w_next_state == S_WRITE) || (w_next_state == S_WR_RD);
    assign w_do_rd = (w_next_state == S_READ)  || (w_next_state == S_WR_RD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_INIT;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ack <= w_do_wr;
            r_rd_ack <= w_do_rd;
            r_wr_err <= (w_next_state == S_WR_ERROR);
            r_rd_err <= w_rd_err_nxt;
            if (w_do_wr) r_tail <= r_tail + 1'b1;
            if (w_do_rd) begin
                r_head <= r_head + 1'b1;
                r_dout <= r_mem[r_head];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // storage is intentionally not reset; a full-and-WR_RD edge reads the old head entry
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_tail] <= fifo.d_in;
    end

    assign fifo.d_out        = r_dout;
    assign fifo.data_count   = r_count;
    assign fifo.state        = r_state;
    assign fifo.full         = (r_count == FULL_C);
    assign fifo.empty        = (r_count == '0);
    assign fifo.almost_full  = (r_count >= AF_C);
    assign fifo.almost_empty = (r_count <= AE_C);
    assign fifo.wr_ack       = r_wr_ack;
    assign fifo.wr_err       = r_wr_err;
    assign fifo.rd_ack       = r_rd_ack;
    assign fifo.rd_err       = r_rd_err;

`ifdef PARAM_FIFO_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [ERR_CNT_W-1:0] r_wr_err_cnt;
    logic [ERR_CNT_W-1:0] r_rd_err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_err_cnt <= '0;
            r_rd_err_cnt <= '0;
        end else begin
            if ((w_next_state == S_WR_ERROR) && (r_wr_err_cnt != ERR_MAX))
                r_wr_err_cnt <= r_wr_err_cnt + 1'b1;
            if (w_rd_err_nxt && (r_rd_err_cnt != ERR_MAX))
                r_rd_err_cnt <= r_rd_err_cnt + 1'b1;
        end
    end

    assign fifo.wr_err_cnt = r_wr_err_cnt;
    assign fifo.rd_err_cnt = r_rd_err_cnt;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: DEPTH=8 and DEPTH=4 instances share one stimulus
// stream and are compared each cycle against a queue-based reference model.
module tb_param_fifo;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        t_wr;
    logic        t_rd;
    logic [31:0] t_din;

    always #5 clk = ~clk;

    param_fifo_if #(.DATA_WIDTH(32), .DEPTH(8)) if8 ();
    param_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) if4 ();

    assign if8.wr_en = t_wr;
    assign if8.rd_en = t_rd;
    assign if8.d_in  = t_din;
    assign if4.wr_en = t_wr;
    assign if4.rd_en = t_rd;
    assign if4.d_in  = t_din;

    param_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .fifo    (if8.slave)
    );

    param_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .fifo    (if4.slave)
    );

    // reference model: index 0 is the DEPTH=8 instance, index 1 the DEPTH=4 one
    logic [31:0] q8[$];
    logic [31:0] q4[$];
    int          m_depth [2] = '{8, 4};
    int          m_af    [2] = '{7, 3};
    int          m_ae    [2] = '{1, 1};
    int          e_state [2];
    int          e_count [2];
    logic [31:0] e_dout  [2];
    bit          e_wack  [2];
    bit          e_werr  [2];
    bit          e_rack  [2];
    bit          e_rerr  [2];
    int          e_wcnt  [2];
    int          e_rcnt  [2];

    int vectors     = 0;
    int miscompares = 0;

    task automatic model_reset();
        q8.delete();
        q4.delete();
        for (int i = 0; i < 2; i++) begin
            e_state[i] = 0;
            e_count[i] = 0;
            e_dout[i]  = '0;
            e_wack[i]  = 1'b0;
            e_werr[i]  = 1'b0;
            e_rack[i]  = 1'b0;
            e_rerr[i]  = 1'b0;
            e_wcnt[i]  = 0;
            e_rcnt[i]  = 0;
        end
    endtask

    task automatic model_step(input int id, input bit wr, input bit rd, input logic [31:0] din);
        logic [31:0] q[$];
        if (id == 0) q = q8;
        else         q = q4;
        e_wack[id] = 1'b0;
        e_werr[id] = 1'b0;
        e_rack[id] = 1'b0;
        e_rerr[id] = 1'b0;
        if (wr && rd) begin
            if (q.size() > 0) begin
                e_state[id] = 6;
                e_dout[id]  = q.pop_front();
                q.push_back(din);
                e_wack[id]  = 1'b1;
                e_rack[id]  = 1'b1;
            end else begin
                e_state[id] = 1;
                q.push_back(din);
                e_wack[id]  = 1'b1;
                e_rerr[id]  = 1'b1;
            end
        end else if (wr) begin
            if (q.size() < m_depth[id]) begin
                e_state[id] = 1;
                q.push_back(din);
                e_wack[id]  = 1'b1;
            end else begin
                e_state[id] = 3;
                e_werr[id]  = 1'b1;
            end
        end else if (rd) begin
            if (q.size() > 0) begin
                e_state[id] = 2;
                e_dout[id]  = q.pop_front();
                e_rack[id]  = 1'b1;
            end else begin
                e_state[id] = 4;
                e_rerr[id]  = 1'b1;
            end
        end else begin
            e_state[id] = 5;
        end
        if (e_werr[id] && e_wcnt[id] < 255) e_wcnt[id]++;
        if (e_rerr[id] && e_rcnt[id] < 255) e_rcnt[id]++;
        e_count[id] = q.size();
        if (id == 0) q8 = q;
        else         q4 = q;
    endtask

    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (depth %0d) observed=0x%0h expected=0x%0h", tag, m_depth[id], obs, exp);
        end
    endtask

    task automatic check_dut(input int id);
        logic [31:0] st, cnt, dout;
        logic f, e, af, ae, wa, we, ra, re;
`ifdef PARAM_FIFO_ERR_CNT_EN
        logic [31:0] wc, rc;
`endif
        if (id == 0) begin
            st = 32'(if8.state); cnt = 32'(if8.data_count); dout = if8.d_out;
            f = if8.full; e = if8.empty; af = if8.almost_full; ae = if8.almost_empty;
            wa = if8.wr_ack; we = if8.wr_err; ra = if8.rd_ack; re = if8.rd_err;
`ifdef PARAM_FIFO_ERR_CNT_EN
            wc = 32'(if8.wr_err_cnt); rc = 32'(if8.rd_err_cnt);
`endif
        end else begin
            st = 32'(if4.state); cnt = 32'(if4.data_count); dout = if4.d_out;
            f = if4.full; e = if4.empty; af = if4.almost_full; ae = if4.almost_empty;
            wa = if4.wr_ack; we = if4.wr_err; ra = if4.rd_ack; re = if4.rd_err;
`ifdef PARAM_FIFO_ERR_CNT_EN
            wc = 32'(if4.wr_err_cnt); rc = 32'(if4.rd_err_cnt);
`endif
        end
        chk("state",        id, st,      32'(e_state[id]));
        chk("data_count",   id, cnt,     32'(e_count[id]));
        chk("d_out",        id, dout,    e_dout[id]);
        chk("full",         id, 32'(f),  32'(e_count[id] == m_depth[id]));
        chk("empty",        id, 32'(e),  32'(e_count[id] == 0));
        chk("almost_full",  id, 32'(af), 32'(e_count[id] >= m_af[id]));
        chk("almost_empty", id, 32'(ae), 32'(e_count[id] <= m_ae[id]));
        chk("wr_ack",       id, 32'(wa), 32'(e_wack[id]));
        chk("wr_err",       id, 32'(we), 32'(e_werr[id]));
        chk("rd_ack",       id, 32'(ra), 32'(e_rack[id]));
        chk("rd_err",       id, 32'(re), 32'(e_rerr[id]));
`ifdef PARAM_FIFO_ERR_CNT_EN
        chk("wr_err_cnt",   id, wc,      32'(e_wcnt[id]));
        chk("rd_err_cnt",   id, rc,      32'(e_rcnt[id]));
`endif
    endtask

    task automatic cycle(input bit wr, input bit rd, input logic [31:0] din);
        t_wr  = wr;
        t_rd  = rd;
        t_din = din;
        model_step(0, wr, rd, din);
        model_step(1, wr, rd, din);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        t_wr    = 1'b0;
        t_rd    = 1'b0;
        t_din   = '0;
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        #10;
        reset_n = 1'b1;

        // fill to full with 0x11..0x88, then one refused write
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'((i + 1) * 'h11));
        chk("full_after_fill", 0, 32'(if8.full), 32'd1);
        cycle(1'b1, 1'b0, 32'h99);
        chk("wr_error_state", 0, 32'(if8.state), 32'(ST_WR_ERROR));

        // drain in order, then one refused read holding the last word
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        chk("rd_error_hold", 0, if8.d_out, 32'h88);

        // simultaneous read/write at mid occupancy, at empty, and at full
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'hA0 + 32'(i));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'hB0 + 32'(i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 32'hC0);
        cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'hD0 + 32'(i));
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 32'hE0 + 32'(i));
        cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        // reset between edges with data in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'hF0 + 32'(i));
        async_reset();

        // random traffic, write-heavy then read-heavy, wrapping both depths
        for (int i = 0; i < 100; i++)
            cycle($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 45, $urandom());
        for (int i = 0; i < 100; i++)
            cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 60, $urandom());

`ifdef PARAM_FIFO_ERR_CNT_EN
        async_reset();
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, '0);
        chk("rd_err_cnt_sat", 0, 32'(if8.rd_err_cnt), 32'd255);
        chk("rd_err_cnt_sat", 1, 32'(if4.rd_err_cnt), 32'd255);
`endif

        t_wr = 1'b0;
        t_rd = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO with a built-in control state machine.
- Generalises the fixed 8-entry FIFO control to any power-of-two depth and any data width.
- Adds a simultaneous read/write state, almost-full/almost-empty flags and registered acknowledge/error strobes.
- Sits between a producer and a consumer in the same clock domain; instantiated by the matrix datapath as its operand buffer.

Parameters:
- DATA_WIDTH, 32, width of d_in/d_out.
- DEPTH, 8, number of entries; power of two, minimum 2.
- AF_LEVEL, DEPTH-1, almost_full asserted when data_count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserted when data_count <= AE_LEVEL.
- CNT_W, $clog2(DEPTH)+1, width of data_count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- d_in  in  DATA_WIDTH  write data.
- d_out  out  DATA_WIDTH  read data, registered.
- full  out  1  data_count == DEPTH.
- empty  out  1  data_count == 0.
- almost_full  out  1  data_count >= AF_LEVEL.
- almost_empty  out  1  data_count <= AE_LEVEL.
- wr_ack  out  1  write accepted last edge.
- wr_err  out  1  write refused (full) last edge.
- rd_ack  out  1  read accepted last edge; d_out valid.
- rd_err  out  1  read refused (empty) last edge.
- data_count  out  CNT_W  current occupancy, 0..DEPTH.
- state  out  3  current FSM state, for debug/verification.

Behaviour:
- Interface: one clock clk; reset_n asynchronous, active-low. On reset_n=0, immediately and regardless of clk: state=INIT, head=tail=0, data_count=0, d_out=0, empty=1, almost_empty=1, full=0, almost_full=(AF_LEVEL==0), all ack/err=0. Memory contents are not reset.
- FSM states: INIT=0, WRITE=1, READ=2, WR_ERROR=3, RD_ERROR=4, NO_OP=5, WR_RD=6. State and datapath update on the same edge.
- next_state is computed from (wr_en, rd_en, data_count) and is identical from every state; no X assignment.
  - wr only: count<DEPTH -> WRITE; else WR_ERROR.
  - rd only: count>0 -> READ; else RD_ERROR.
  - both: count>0 -> WR_RD; count==0 -> WRITE with rd_err=1.
  - neither -> NO_OP.
- WRITE: mem[tail]<=d_in, tail+1 mod DEPTH, count+1, wr_ack=1.
- READ: d_out<=mem[head], head+1, count-1, rd_ack=1. Latency: d_out valid at the edge that raises rd_ack.
- WR_RD: write and read on the same edge, count unchanged, wr_ack=rd_ack=1. Allowed when full because the read frees a slot; a read at count==1 returns the old entry, not d_in.
- WR_ERROR: no pointer or count change, wr_err=1. RD_ERROR: no change, d_out holds, rd_err=1.
- NO_OP: everything holds; ack/err=0.
- ack/err are single-cycle strobes recomputed every edge.
- Flags are derived from the registered data_count, so they are valid in the same cycle as the count.
- Pointers are $clog2(DEPTH) bits and wrap naturally; data_count never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: PARAM_FIFO_ERR_CNT_EN.
- Defined: adds outputs wr_err_cnt[7:0] and rd_err_cnt[7:0]. Each increments on every wr_err/rd_err edge and saturates at 255. Both clear on reset_n=0 only.
- Undefined: the ports and the counters do not exist.

Decomposition:
- Package fifo_pkg holds:
  - state encodings INIT..WR_RD as 3-bit localparams;
  - the err-counter width (8).
- One sub-module, param_fifo_ns: combinational next-state logic with inputs wr_en, rd_en, data_count and state. The parent holds the registers, memory and datapath.

Test Plan:
- Reset mid-stream: after 3 writes, pulse reset_n low between edges -> count=0, empty=1, state=INIT immediately, without waiting for clk.
- DEPTH=8: 8 writes of 0x11..0x88 -> wr_ack each cycle, full=1, almost_full from count 7. A 9th write -> wr_err=1, state=WR_ERROR, count stays 8.
- From full, 8 reads -> d_out 0x11..0x88 in order, each with rd_ack. A 9th read -> rd_err=1, state=RD_ERROR, d_out holds 0x88.
- Simultaneous rd/wr:
  - count=4 -> WR_RD, count stays 4, FIFO order preserved.
  - count=0 -> WRITE with rd_err=1, count=1.
  - count=8 -> count stays 8, wr_ack=rd_ack=1.
- Wrap: DEPTH=4, 50 random cycles of rd/wr against a scoreboard -> no data mismatch; count and flags match the model every cycle.
- With PARAM_FIFO_ERR_CNT_EN defined: 300 reads on an empty FIFO -> rd_err_cnt saturates at 255.
